uart_rx: RTL and testbench

UART receiver, the receive-side counterpart of the `uart_tx` path. It accepts an asynchronous serial line, detects the start bit, and samples each bit at mid-bit using a fixed clock-per-bit count. It deserializes LSB-first data and presents each completed byte with a one-cycle valid strobe. It sits between the pad/line input and the host-side consumer; there is no internal FIFO.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_rx_if.sv | 21 ++
 rtl/sync2.sv | 16 +
 rtl/uart_rx.sv | 112 +++++++++++
 tb/tb_uart_rx.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding and default frame parameters
// Contents: rx_state_t (IDLE, START, DATA, PARITY, STOP), UART_DATA_WIDTH, UART_CLKS_PER_BIT
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_CLKS_PER_BIT = 16;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: line input and host-side outputs of the UART receiver
// Signals: rx (serial line in), dout/valid (received word + strobe), frame_err, busy,
//          parity_err only when UART_RX_PARITY_EN is defined
// Modports: master = receiver side, slave = line driver / host consumer side
interface uart_rx_if import uart_pkg::*; #(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
);
  logic rx;
  logic [DATA_WIDTH-1:0] dout;
  logic valid;
  logic frame_err;
  logic busy;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
  modport master (input rx, output dout, valid, frame_err, busy, parity_err);
  modport slave (output rx, input dout, valid, frame_err, busy, parity_err);
`else
  modport master (input rx, output dout, valid, frame_err, busy);
  modport slave (output rx, input dout, valid, frame_err, busy);
`endif
endinterface

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous single-bit input
// Ports: clk, reset (async active-high), d (async in), q (synchronized out)
// RESET_VAL sets the value both flops take during reset
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge reset)
    if (reset) {q, m} <= {2{RESET_VAL}};
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, mid-bit sampling, LSB-first, one-cycle valid/frame_err strobes
// Ports: clk, reset (async active-high), bus (uart_rx_if.master: rx in; dout, valid,
//        frame_err, busy out; parity_err out with UART_RX_PARITY_EN)
// Macro UART_RX_PARITY_EN adds an even-parity bit after the data bits
module uart_rx import uart_pkg::*; #(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input logic clk,
  input logic reset,
  uart_rx_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
`else
  localparam rx_state_t AFTER_DATA = STOP;
`endif
  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d, dout_q, dout_d;
  logic valid_q, valid_d, ferr_q, ferr_d, rx_s, rx_d, bit_end;
  sync2 #(.RESET_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .d(bus.rx), .q(rx_s));
  assign bit_end = cnt_q == FULL_M1;
  assign bus.dout = dout_q;
  assign bus.valid = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
  assign bus.parity_err = perr_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) {par_q, perr_q} <= 2'b00;
    else {par_q, perr_q} <= {par_d, perr_d};
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      dout_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      rx_d <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      rx_d <= rx_s;
    end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    sh_d = sh_q;
    dout_d = dout_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d = par_q;
    perr_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // only a high-to-low transition starts a frame, so a held-low line never retriggers
        if (rx_d && !rx_s) state_d = START;
      end
      START: if (cnt_q == HALF_M1) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (bit_end) begin
        cnt_d = '0;
        sh_d = {rx_s, sh_q[DATA_WIDTH-1:1]};
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = AFTER_DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_end) begin
        cnt_d = '0;
        par_d = ^{sh_q, rx_s};
        state_d = STOP;
      end
`endif
      STOP: if (bit_end) begin
        // returning to IDLE mid-stop-bit lets a back-to-back start edge be caught
        cnt_d = '0;
        state_d = IDLE;
        if (rx_s) begin
          dout_d = sh_q;
          valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_d = par_q;
`endif
        end else ferr_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven, scoreboard-checked bench for uart_rx (honours UART_RX_PARITY_EN)
module tb_uart_rx;
  import uart_pkg::*;
  localparam int DW = UART_DATA_WIDTH;
  localparam int C = UART_CLKS_PER_BIT;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam longint LAT = 3 + C / 2 + (DW + 1 + PB) * C;
  typedef struct {
    logic [DW-1:0] data;
    logic stop;
    logic pflip;
    logic exp_ferr;
    logic exp_perr;
  } vec_t;
  typedef struct {
    logic [DW-1:0] data;
    logic ferr;
    logic perr;
    longint t0;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int passes = 0;
  logic [DW-1:0] last_good = '0;
  logic pend = 1'b0;
  logic pv = 1'b0;
  logic pf = 1'b0;
  exp_t sb[$];
  exp_t me;
  longint mn;
  vec_t tbl[$];
  uart_rx_if bus ();
  uart_rx dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic ok, input longint act, input longint exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  task automatic send(input vec_t v);
    exp_t e;
    bus.rx = 1'b0;
    e.t0 = $time;
    e.data = v.data;
    e.ferr = v.exp_ferr;
    e.perr = v.exp_perr;
    sb.push_back(e);
    repeat (C) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      bus.rx = v.data[i];
      repeat (C) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    bus.rx = (^v.data) ^ v.pflip;
    repeat (C) @(negedge clk);
`endif
    bus.rx = v.stop;
    repeat (C) @(negedge clk);
  endtask
  task automatic chk_reset_vals();
    chk("rst_dout", bus.dout == '0, bus.dout, 0);
    chk("rst_valid", bus.valid == 1'b0, bus.valid, 0);
    chk("rst_frame_err", bus.frame_err == 1'b0, bus.frame_err, 0);
    chk("rst_busy", bus.busy == 1'b0, bus.busy, 0);
`ifdef UART_RX_PARITY_EN
    chk("rst_parity_err", bus.parity_err == 1'b0, bus.parity_err, 0);
`endif
  endtask
  always @(negedge clk) begin
    if (reset) begin
      pend = 1'b0;
      pv = 1'b0;
      pf = 1'b0;
    end else begin
      if (pend) chk("pulse_width", !bus.valid && !bus.frame_err, {bus.valid, bus.frame_err}, 0);
      pend = 1'b0;
      if ((bus.valid && !pv) || (bus.frame_err && !pf)) begin
        pend = 1'b1;
        if (sb.size() == 0) chk("unexpected_strobe", 1'b0, {bus.valid, bus.frame_err}, 0);
        else begin
          me = sb.pop_front();
          mn = ($time - me.t0) / 10;
          chk("strobe_exclusive", !(bus.valid && bus.frame_err), {bus.valid, bus.frame_err}, 1);
          chk("strobe_kind", bus.frame_err == me.ferr, bus.frame_err, me.ferr);
          chk("dout", bus.dout == (me.ferr ? last_good : me.data), bus.dout, me.ferr ? last_good : me.data);
          chk("busy_after_stop", !bus.busy, bus.busy, 0);
          chk("latency", mn == LAT || mn == LAT + 1, mn, LAT);
`ifdef UART_RX_PARITY_EN
          chk("parity_err", bus.parity_err == (me.perr && !me.ferr), bus.parity_err, me.perr && !me.ferr);
`endif
          if (!me.ferr) last_good = me.data;
        end
      end
      pv = bus.valid;
      pf = bus.frame_err;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
    $fatal(1);
  end
  initial begin
    tbl.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{8'hC3, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{8'h01, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{8'h80, 1'b1, 1'b0, 1'b0, 1'b0});
`ifdef UART_RX_PARITY_EN
    tbl.push_back('{8'h07, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{8'h07, 1'b1, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{8'h07, 1'b0, 1'b1, 1'b1, 1'b0});
`endif
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send('{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0});
    repeat (C) @(negedge clk);
    chk("a5_dout", bus.dout == 8'hA5, bus.dout, 8'hA5);
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    chk("glitch_busy", bus.busy == 1'b1, bus.busy, 1);
    repeat (2 * C) @(negedge clk);
    chk("glitch_idle", bus.busy == 1'b0, bus.busy, 0);
    chk("glitch_dout", bus.dout == 8'hA5, bus.dout, 8'hA5);
    send('{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0});
    repeat (3 * C) @(negedge clk);
    chk("break_idle", bus.busy == 1'b0, bus.busy, 0);
    chk("break_dout", bus.dout == 8'hA5, bus.dout, 8'hA5);
    bus.rx = 1'b1;
    repeat (C) @(negedge clk);
    foreach (tbl[i]) begin
      send(tbl[i]);
      if (!tbl[i].stop) begin
        bus.rx = 1'b1;
        repeat (C) @(negedge clk);
      end
    end
    repeat (C) @(negedge clk);
    bus.rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.rx = i[0] ? 1'b0 : 1'b1;
      repeat (C) @(negedge clk);
    end
    bus.rx = 1'b0;
    repeat (C / 2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    last_good = '0;
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2 * C) @(negedge clk);
    chk("post_reset_idle", bus.busy == 1'b0, bus.busy, 0);
    chk("post_reset_dout", bus.dout == '0, bus.dout, 0);
    send('{8'h81, 1'b1, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 4 * C && sb.size() != 0; i++) @(negedge clk);
    repeat (C) @(negedge clk);
    chk("scoreboard_drained", sb.size() == 0, sb.size(), 0);
    chk("final_dout", bus.dout == 8'h81, bus.dout, 8'h81);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
